// File: rtl/spi_peripheral.sv
// SPI mode-0 responder serving a 128x8 register memory.
// The raw cs/sclk/mosi pins are synchronized and debounced into the clk domain.
// A frame is a 7-bit address, an R/W bit and one data byte, all MSB first.

// Input conditioner: 2-flop synchronizer followed by a debounce counter.
// The conditioned level follows the pin only after it has held a new value
// for WAITTIME consecutive clk cycles. The edge pulses are asserted in the
// same cycle as the level change.
module spi_cond #(
  parameter int   WAITTIME     = 3,
  parameter int   COUNTERWIDTH = 3,
  parameter logic INIT         = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam logic [COUNTERWIDTH-1:0] CNT_LAST = COUNTERWIDTH'(WAITTIME - 1);
  localparam logic [COUNTERWIDTH-1:0] CNT_ONE  = COUNTERWIDTH'(1);

  logic                    sync1_r;
  logic                    sync2_r;
  logic                    level_r;
  logic                    rise_r;
  logic                    fall_r;
  logic [COUNTERWIDTH-1:0] cnt_r;

  // Two-flop synchronizer for the asynchronous pin.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_r <= INIT;
      sync2_r <= INIT;
    end else begin
      sync1_r <= pin;
      sync2_r <= sync1_r;
    end
  end

  // Debounce: accept a new value only once it has been stable long enough.
  always_ff @(posedge clk) begin
    if (reset) begin
      level_r <= INIT;
      rise_r  <= 1'b0;
      fall_r  <= 1'b0;
      cnt_r   <= '0;
    end else begin
      rise_r <= 1'b0;
      fall_r <= 1'b0;
      if (sync2_r != level_r) begin
        if (cnt_r == CNT_LAST) begin
          level_r <= sync2_r;
          rise_r  <= sync2_r;
          fall_r  <= ~sync2_r;
          cnt_r   <= '0;
        end else begin
          cnt_r <= cnt_r + CNT_ONE;
        end
      end else begin
        cnt_r <= '0;
      end
    end
  end

  assign level = level_r;
  assign rise  = rise_r;
  assign fall  = fall_r;

endmodule

module spi_peripheral #(
  parameter int WAITTIME     = 3,
  parameter int COUNTERWIDTH = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic sclk,
  input  logic cs,
  input  logic mosi,
  output logic miso,
  output logic miso_oe
);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    GET_ADDR    = 3'd1,
    READ_LOAD   = 3'd2,
    READ_SHIFT  = 3'd3,
    WRITE_SHIFT = 3'd4,
    WRITE_MEM   = 3'd5,
    DONE        = 3'd6
  } state_t;

  // Conditioned pin views.
  logic cs_level_s, cs_rise_s, cs_fall_s;
  logic sclk_level_s, sclk_rise_s, sclk_fall_s;
  logic mosi_level_s, mosi_rise_s, mosi_fall_s;
  logic unused_edges_s;

  // Registered state and datapath.
  state_t     state_r, state_s;
  logic [2:0] bit_cnt_r, bit_cnt_s;
  logic [7:0] shift_r, shift_s;
  logic [6:0] addr_r, addr_s;
  logic       miso_bit_r, miso_bit_s;
  logic       rd_r, rd_s;
  logic       miso_r, miso_s;
  logic       miso_oe_r, miso_oe_s;
  logic       mem_we_s;

  logic [7:0] mem_r [0:127];

  spi_cond #(.WAITTIME(WAITTIME), .COUNTERWIDTH(COUNTERWIDTH), .INIT(1'b1)) u_cs_cond (
    .clk(clk), .reset(reset), .pin(cs),
    .level(cs_level_s), .rise(cs_rise_s), .fall(cs_fall_s)
  );

  spi_cond #(.WAITTIME(WAITTIME), .COUNTERWIDTH(COUNTERWIDTH), .INIT(1'b0)) u_sclk_cond (
    .clk(clk), .reset(reset), .pin(sclk),
    .level(sclk_level_s), .rise(sclk_rise_s), .fall(sclk_fall_s)
  );

  spi_cond #(.WAITTIME(WAITTIME), .COUNTERWIDTH(COUNTERWIDTH), .INIT(1'b0)) u_mosi_cond (
    .clk(clk), .reset(reset), .pin(mosi),
    .level(mosi_level_s), .rise(mosi_rise_s), .fall(mosi_fall_s)
  );

  // The cs level alone decides release, so these edges are not needed.
  assign unused_edges_s = ^{cs_rise_s, sclk_level_s, mosi_rise_s, mosi_fall_s};

  // Next-state and datapath logic; a high cs level overrides every state.
  always_comb begin
    state_s    = state_r;
    bit_cnt_s  = bit_cnt_r;
    shift_s    = shift_r;
    addr_s     = addr_r;
    miso_bit_s = miso_bit_r;
    rd_s       = rd_r;
    mem_we_s   = 1'b0;

    if (cs_level_s) begin
      state_s   = IDLE;
      bit_cnt_s = 3'd0;
      rd_s      = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (cs_fall_s) begin
            state_s    = GET_ADDR;
            bit_cnt_s  = 3'd0;
            miso_bit_s = 1'b0;
            rd_s       = 1'b0;
          end else begin
            state_s = IDLE;
          end
        end
        GET_ADDR: begin
          if (sclk_rise_s) begin
            shift_s = {shift_r[6:0], mosi_level_s};
            if (bit_cnt_r == 3'd7) begin
              bit_cnt_s = 3'd0;
              addr_s    = shift_r[6:0];
              if (mosi_level_s) begin
                state_s = READ_LOAD;
                rd_s    = 1'b1;
              end else begin
                state_s = WRITE_SHIFT;
              end
            end else begin
              bit_cnt_s = bit_cnt_r + 3'd1;
            end
          end else begin
            state_s = GET_ADDR;
          end
        end
        READ_LOAD: begin
          shift_s   = mem_r[addr_r];
          bit_cnt_s = 3'd0;
          state_s   = READ_SHIFT;
        end
        READ_SHIFT: begin
          if (sclk_fall_s) begin
            miso_bit_s = shift_r[7];
            shift_s    = {shift_r[6:0], 1'b0};
            if (bit_cnt_r == 3'd7) begin
              bit_cnt_s = 3'd0;
              state_s   = DONE;
            end else begin
              bit_cnt_s = bit_cnt_r + 3'd1;
            end
          end else begin
            state_s = READ_SHIFT;
          end
        end
        WRITE_SHIFT: begin
          if (sclk_rise_s) begin
            shift_s = {shift_r[6:0], mosi_level_s};
            if (bit_cnt_r == 3'd7) begin
              bit_cnt_s = 3'd0;
              state_s   = WRITE_MEM;
            end else begin
              bit_cnt_s = bit_cnt_r + 3'd1;
            end
          end else begin
            state_s = WRITE_SHIFT;
          end
        end
        WRITE_MEM: begin
          mem_we_s = 1'b1;
          state_s  = DONE;
        end
        DONE: begin
          state_s = DONE;
        end
        default: begin
          state_s = IDLE;
        end
      endcase
    end

    // Outputs are derived from the next state so the registered pins
    // line up exactly with the state they belong to.
    miso_oe_s = (state_s == READ_LOAD) || (state_s == READ_SHIFT) ||
                ((state_s == DONE) && rd_s);
    if (miso_oe_s) begin
      miso_s = miso_bit_s;
    end else begin
      miso_s = 1'b0;
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      bit_cnt_r  <= 3'd0;
      shift_r    <= 8'd0;
      addr_r     <= 7'd0;
      miso_bit_r <= 1'b0;
      rd_r       <= 1'b0;
      miso_r     <= 1'b0;
      miso_oe_r  <= 1'b0;
    end else begin
      state_r    <= state_s;
      bit_cnt_r  <= bit_cnt_s;
      shift_r    <= shift_s;
      addr_r     <= addr_s;
      miso_bit_r <= miso_bit_s;
      rd_r       <= rd_s;
      miso_r     <= miso_s;
      miso_oe_r  <= miso_oe_s;
    end
  end

  // Register memory write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we_s && !reset) begin
      mem_r[addr_r] <= shift_r;
    end
  end

  assign miso    = miso_r;
  assign miso_oe = miso_oe_r;

endmodule

// File: tb/tb_spi_peripheral.sv
// Directed plus randomized bench for spi_peripheral acting as an SPI controller.
// A byte-array model of the register memory predicts every read.
module tb_spi_peripheral;

  localparam int HP = 14;  // sclk half period in clk cycles

  logic clk = 1'b0;
  logic reset, sclk, cs, mosi;
  logic miso, miso_oe;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem_m   [128];
  bit         known_m [128];

  spi_peripheral #(.WAITTIME(3), .COUNTERWIDTH(3)) dut (
    .clk(clk), .reset(reset), .sclk(sclk), .cs(cs),
    .mosi(mosi), .miso(miso), .miso_oe(miso_oe)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One SPI frame. nbits < 16 aborts early; extra adds sclk pulses after bit 15;
  // glitch injects a 1-cycle cs high glitch and a 2-cycle sclk pulse in each low phase.
  task automatic frame(input logic [7:0] b0, input logic [7:0] b1, input int nbits,
                       input int extra, input int gap, input bit glitch,
                       input logic [7:0] exp_rd, input string tag);
    logic is_rd;
    logic exp_oe;
    is_rd = b0[0];
    cs = 1'b0;
    tick(HP);
    for (int i = 0; i < nbits; i++) begin
      mosi = (i < 8) ? b0[7 - i] : b1[15 - i];
      if (glitch) begin
        tick(3); cs = 1'b1; tick(1); cs = 1'b0;
        tick(3); sclk = 1'b1; tick(2); sclk = 1'b0;
        tick(HP - 9);
      end else begin
        tick(HP);
      end
      sclk = 1'b1;
      exp_oe = is_rd && (i >= 8);
      check({tag, " oe"}, {7'd0, miso_oe}, {7'd0, exp_oe});
      if (exp_oe) begin
        check($sformatf("%s bit%0d", tag, i), {7'd0, miso}, {7'd0, exp_rd[15 - i]});
      end
      tick(HP);
      sclk = 1'b0;
    end
    for (int e = 0; e < extra; e++) begin
      mosi = 1'($urandom);
      tick(HP);
      sclk = 1'b1;
      check({tag, " extra oe"}, {7'd0, miso_oe}, {7'd0, is_rd});
      tick(HP);
      sclk = 1'b0;
    end
    tick(HP);
    cs = 1'b1;
    tick(gap);
    check({tag, " release oe"}, {7'd0, miso_oe}, 8'd0);
    check({tag, " release miso"}, {7'd0, miso}, 8'd0);
  endtask

  task automatic wr(input logic [6:0] a, input logic [7:0] d, input int extra, input int gap);
    frame({a, 1'b0}, d, 16, extra, gap, 1'b0, 8'd0, $sformatf("wr%02h", a));
    mem_m[a]   = d;
    known_m[a] = 1'b1;
  endtask

  task automatic rd(input logic [6:0] a, input bit glitch);
    frame({a, 1'b1}, 8'($urandom), 16, 0, 20, glitch, mem_m[a], $sformatf("rd%02h", a));
  endtask

  initial begin
    logic [6:0] a;
    for (int k = 0; k < 128; k++) begin
      mem_m[k]   = 8'd0;
      known_m[k] = 1'b0;
    end

    // Reset with cs low and sclk toggling.
    reset = 1'b1; cs = 1'b0; mosi = 1'b0; sclk = 1'b0;
    tick(1);
    sclk = 1'b1;
    tick(1);
    sclk = 1'b0;
    check("reset miso", {7'd0, miso}, 8'd0);
    check("reset oe", {7'd0, miso_oe}, 8'd0);
    reset = 1'b0;
    cs = 1'b1;
    tick(30);
    check("post reset oe", {7'd0, miso_oe}, 8'd0);

    // Known neighbours around the addresses under test.
    wr(7'h7F, 8'h00, 0, 20);
    wr(7'h7E, 8'($urandom), 0, 20);
    wr(7'h01, 8'($urandom), 0, 20);
    wr(7'h02, 8'($urandom), 0, 20);

    // Write then read (frames 0x24 and 0x25).
    wr(7'h12, 8'hA5, 0, 20);
    rd(7'h12, 1'b0);

    // Aborted write after the 12th posedge leaves 0x7F untouched.
    frame({7'h7F, 1'b0}, 8'h3C, 12, 0, 20, 1'b0, 8'd0, "abort");
    rd(7'h7F, 1'b0);

    // Boundary addresses.
    wr(7'h00, 8'hFF, 0, 20);
    wr(7'h7F, 8'h01, 0, 20);
    rd(7'h00, 1'b0);
    rd(7'h7F, 1'b0);
    rd(7'h01, 1'b0);
    rd(7'h7E, 1'b0);
    rd(7'h02, 1'b0);
    rd(7'h12, 1'b0);

    // Glitches while idle must not start a frame.
    cs = 1'b0; tick(1); cs = 1'b1; tick(3);
    sclk = 1'b1; tick(2); sclk = 1'b0; tick(12);
    check("glitch idle oe", {7'd0, miso_oe}, 8'd0);
    // Glitches inside a read frame must neither abort it nor shift it.
    rd(7'h12, 1'b1);

    // Extra sclk pulses after a write, then a back-to-back read.
    wr(7'h33, 8'h5C, 4, 10);
    rd(7'h33, 1'b0);

    // Randomized traffic.
    for (int k = 0; k < 10; k++) begin
      a = 7'($urandom_range(0, 127));
      if (known_m[a] && ($urandom_range(0, 1) == 1)) begin
        rd(a, 1'b0);
      end else begin
        wr(a, 8'($urandom), 0, 20);
        rd(a, 1'b0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
